// File: rtl/pipeline_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_ctrl
//   Central pipeline controller for the five-stage core.
//   - Merges per-stage stall requests into the 6-bit stall vector that holds
//     the PC register and the IF/ID, ID/EX, EX/MEM, MEM/WB pipeline registers.
//   - Sequences exception / ERET redirects: freeze the pipeline, wait for any
//     outstanding AXI-Lite fetch or data transaction to drain, then issue a
//     one-cycle flush together with the redirect PC.
//   - Counts cycles in which the PC is held (stall[0]=1).
//
// Ports
//   clk           core clock
//   rst           asynchronous, active-low reset
//   stallreq_if   IF AXI fetch outstanding
//   stallreq_id   ID load-use hazard
//   stallreq_ex   EX multi-cycle op busy
//   stallreq_mem  MEM AXI data access outstanding
//   exc_valid     MEM stage reports exception or ERET this cycle
//   exc_code      exception type (ERET_CODE selects cp0_epc as target)
//   cp0_epc       current EPC from CP0
//   stall         hold vector, bit0 PC ... bit5 WB (combinational)
//   flush         registered, clears all pipeline registers
//   new_pc        registered redirect target, valid while flush=1
//   stall_cnt     free-running count of cycles with stall[0]=1
// -----------------------------------------------------------------------------
module pipeline_ctrl #(
    parameter logic [31:0] EBASE     = 32'hBFC00380,
    parameter logic [4:0]  ERET_CODE = 5'h0E,
    parameter int          CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stallreq_if,
    input  logic             stallreq_id,
    input  logic             stallreq_ex,
    input  logic             stallreq_mem,
    input  logic             exc_valid,
    input  logic [4:0]       exc_code,
    input  logic [31:0]      cp0_epc,
    output logic [5:0]       stall,
    output logic             flush,
    output logic [31:0]      new_pc,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    localparam logic [5:0]       STALL_ALL  = 6'b111111;
    localparam logic [5:0]       STALL_MEM  = 6'b011111;
    localparam logic [5:0]       STALL_EX   = 6'b001111;
    localparam logic [5:0]       STALL_ID   = 6'b000111;
    localparam logic [5:0]       STALL_IF   = 6'b000011;
    localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           r_state;
    state_t           w_next_state;
    logic [31:0]      r_target;
    logic [31:0]      r_new_pc;
    logic             r_flush;
    logic [CNT_W-1:0] r_stall_cnt;

    logic             w_busy;
    logic [31:0]      w_exc_target;
    logic [31:0]      w_flush_pc;

    // A redirect may only be issued once no AXI transaction is in flight,
    // otherwise a late response would land in the flushed pipeline.
    assign w_busy       = stallreq_if | stallreq_mem;
    assign w_exc_target = (exc_code == ERET_CODE) ? cp0_epc : EBASE;

    // -------------------------------------------------------------------------
    // Next state and stall vector
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case statement can leave one unassigned and infer a latch.
        w_next_state = r_state;
        stall        = 6'b000000;
        w_flush_pc   = r_target;

        case (r_state)
            ST_IDLE: begin
                if (exc_valid) begin
                    stall        = STALL_ALL;
                    // Target bypasses the latch so the no-drain case can
                    // present new_pc on the very next cycle.
                    w_flush_pc   = w_exc_target;
                    w_next_state = w_busy ? ST_DRAIN : ST_FLUSH;
                end else if (stallreq_mem) begin
                    stall = STALL_MEM;
                end else if (stallreq_ex) begin
                    stall = STALL_EX;
                end else if (stallreq_id) begin
                    stall = STALL_ID;
                end else if (stallreq_if) begin
                    stall = STALL_IF;
                end
            end

            ST_DRAIN: begin
                // Later exceptions are ignored: the first one wins.
                stall = STALL_ALL;
                if (!w_busy) begin
                    w_next_state = ST_FLUSH;
                end
            end

            ST_FLUSH: begin
                // Pipeline is being cleared; every request this cycle is moot.
                w_next_state = ST_IDLE;
            end

            default: begin
                w_next_state = ST_IDLE;
            end
        endcase

        // stall is combinational, so it must also read zero while reset is
        // held, independent of whatever the stage requests are doing.
        if (!rst) begin
            stall = 6'b000000;
        end
    end

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so all
        // registers update from the same pre-edge values.
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // -------------------------------------------------------------------------
    // Redirect target latch and registered flush / new_pc
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_target <= 32'h0;
            r_flush  <= 1'b0;
            r_new_pc <= 32'h0;
        end else begin
            if (r_state == ST_IDLE && exc_valid) begin
                r_target <= w_exc_target;
            end
            r_flush <= (w_next_state == ST_FLUSH);
            // new_pc only changes when a flush is about to be presented and
            // keeps its last value otherwise.
            if (w_next_state == ST_FLUSH) begin
                r_new_pc <= w_flush_pc;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Stall-cycle performance counter (wraps, no saturation)
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cnt <= '0;
        end else if (stall[0]) begin
            r_stall_cnt <= r_stall_cnt + CNT_ONE;
        end
    end

    assign flush     = r_flush;
    assign new_pc    = r_new_pc;
    assign stall_cnt = r_stall_cnt;

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Central pipeline controller for the five-stage core.
- Merges per-stage stall requests into the 6-bit stall vector consumed by the PC register and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- Sequences exception and ERET redirects. It freezes the pipeline, waits for any outstanding AXI-Lite fetch or data transaction to drain, then issues a one-cycle flush with the redirect PC.
- Also keeps a stall-cycle performance counter.

Parameters:
- EBASE, 32'hBFC00380, exception handler entry PC.
- ERET_CODE, 5'h0E, exc_code value meaning ERET (redirect to cp0_epc).
- CNT_W, 32, width of the stall-cycle counter.

Ports:
- clk  in  1  core clock
- rst  in  1  reset, asynchronous, active-low
- stallreq_if  in  1  IF AXI fetch outstanding / not yet returned
- stallreq_id  in  1  ID load-use hazard
- stallreq_ex  in  1  EX multi-cycle op (mul/div) busy
- stallreq_mem  in  1  MEM AXI data access outstanding
- exc_valid  in  1  MEM stage reports exception or ERET this cycle
- exc_code  in  5  exception type
- cp0_epc  in  32  current EPC from CP0
- stall  out  6  bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM, bit4 MEM/WB, bit5 WB; 1 = hold
- flush  out  1  registered; clears all pipeline registers
- new_pc  out  32  registered redirect target; valid when flush=1
- stall_cnt  out  CNT_W  cycles with stall[0]=1

Behaviour:
- State machine: IDLE, DRAIN, FLUSH. State register is 2 bits.
- Define busy = stallreq_if | stallreq_mem.
- Reset (rst=0, asynchronous, takes effect mid-operation):
  - state=IDLE, flush=0, new_pc=0, stall_cnt=0, internal target latch=0.
  - stall is combinational, so it is 6'b000000 during reset.
- IDLE, exc_valid=0: stall is a priority encoding, highest first:
  - stallreq_mem -> 6'b011111
  - stallreq_ex -> 6'b001111
  - stallreq_id -> 6'b000111
  - stallreq_if -> 6'b000011
  - none -> 6'b000000
- IDLE, exc_valid=1:
  - stall=6'b111111 in that cycle, regardless of the stallreq inputs.
  - Latch target: cp0_epc if exc_code==ERET_CODE, else EBASE.
  - Next state: busy=0 -> FLUSH; busy=1 -> DRAIN.
- DRAIN:
  - stall=6'b111111.
  - exc_valid and exc_code are ignored; the first exception wins.
  - Leave for FLUSH on the first cycle busy=0. There is no timeout.
- FLUSH (exactly one cycle):
  - flush=1, new_pc=latched target, stall=6'b000000.
  - All stallreq and exc inputs are ignored.
  - Next state is IDLE unconditionally.
- flush/new_pc are driven from registers and are 1 only while in FLUSH. new_pc holds its last value otherwise.
- Latency: exception detect cycle T with busy=0 -> flush=1 at T+1 -> IDLE at T+2. With busy, flush comes one cycle after busy first reads 0.
- Back-to-back exc_valid in the FLUSH cycle is dropped; the pipeline is being cleared.
- exc_valid=1 in the cycle right after FLUSH (IDLE) is accepted normally.
- stall_cnt increments by 1 on every clock edge where stall[0]=1, in any state. It wraps modulo 2^CNT_W and has no saturation.

Test Plan:
- Reset mid-DRAIN: drive rst=0 asynchronously -> state IDLE, flush=0, new_pc=0, stall_cnt=0 immediately, without waiting for a clock edge.
- Priority: stallreq_id=1 with stallreq_ex=1 -> stall=6'b001111. Add stallreq_mem=1 -> 6'b011111. Only stallreq_if=1 -> 6'b000011.
- Exception, idle bus: exc_valid=1, exc_code=5'h04 at cycle T -> stall=6'b111111 at T. At T+1: flush=1, new_pc=32'hBFC00380, stall=0. At T+2: flush=0.
- ERET during fetch: cp0_epc=32'h80001234, exc_code=5'h0E, stallreq_if=1 for 3 cycles -> stall=6'b111111 for 4 cycles (detect + 3). A second exc_valid with exc_code=5'h08 during DRAIN is ignored. flush=1 with new_pc=32'h80001234 in the cycle after stallreq_if drops.
- Counter: 5 cycles of stallreq_id=1 -> stall_cnt=5. With CNT_W=4 preloaded to 15 by 15 stall cycles, one more stall cycle -> stall_cnt=0.
